inst_fetcher: RTL and testbench
===============================

// Module: inst_fetcher
// PURPOSE
//   Instruction fetch stage upstream of the memory controller. Holds the PC and issues one
//   fetch at a time over the if_enable/if_ready handshake. Advances PC by 2 (RVC) or 4.
//   Buffers fetched instructions, tagged with their PC, in a circular queue for the decoder.
//   Flushes the queue and redirects the PC on clear, in step with the memory controller.
// PARAMETERS
//   DEPTH     8     instruction queue entries; power of two, >= 2
//   RESET_PC  32'h0 PC loaded on reset
// PORTS
//   clk_in       in   1   system clock
//   rst_n_in     in   1   reset, asynchronous, active-low
//   rdy_in       in   1   global ready; all state frozen when low
//   clear        in   1   flush/redirect request (honoured only when rdy_in=1)
//   clear_pc     in   32  new PC applied on clear
//   if_enable    out  1   fetch request to the memory controller
//   inst_addr    out  32  fetch address (= pc register)
//   if_ready     in   1   one-cycle pulse: inst/is_c valid this cycle only
//   inst         in   32  fetched instruction; RVC occupies [15:0]
//   is_c         in   1   fetched instruction is 16-bit
//   iq_valid     out  1   queue head valid
//   iq_ready     in   1   decoder accepts head this cycle
//   iq_inst      out  32  head instruction
//   iq_pc        out  32  head PC
//   iq_is_c      out  1   head is RVC
// BEHAVIOUR
//   Reset (async, rst_n_in=0): pc=RESET_PC, state=IDLE, head=tail=count=0.
//     Outputs: if_enable=0, inst_addr=RESET_PC, iq_valid=0, iq_inst=0, iq_pc=0, iq_is_c=0.
//     Takes effect immediately, including mid-fetch; the in-flight fetch is abandoned.
//   rdy_in=0: no register changes, including when if_ready=1. Outputs hold.
//   FSM, evaluated only when rdy_in=1:
//     IDLE -> WAIT when count < DEPTH and not clear.
//     WAIT -> IDLE on if_ready. Same edge: enqueue {pc, inst, is_c}.
//       Same edge: pc <= pc + (is_c ? 2 : 4), 32-bit, wraps mod 2^32.
//     WAIT with !if_ready: hold; pc and inst_addr stable.
//   if_enable = (state==WAIT) & ~if_ready. The combinational mask stops the controller, idle in
//     the if_ready cycle, from re-issuing the stale address. At most one fetch outstanding.
//   Issue needs only count < DEPTH, with one request in flight, so the enqueue never overflows.
//   Queue:
//     iq_valid = (count != 0).
//     iq_* = entry[head] when valid, else all zero.
//     Dequeue when iq_valid & iq_ready: head <= head+1, wrapping at DEPTH.
//     Enqueue writes entry[tail]; tail <= tail+1, wrapping at DEPTH.
//     Simultaneous enqueue and dequeue: count unchanged. Enqueue or dequeue alone: count +/- 1.
//   Clear (rdy_in & clear): pc <= clear_pc, state <= IDLE, head=tail=count=0.
//     Clear has priority over a same-cycle if_ready: that instruction is dropped.
//     Clear has priority over a same-cycle dequeue.
//     No request is issued in the clear cycle. First fetch of clear_pc goes out one cycle later.
//   No alignment check on the PC: bit 0 passes through unchanged; bit 1 is legal (RVC).
//   Steady-state throughput: one fetch per controller round trip plus one IDLE bubble.
// TESTING
//   1 Reset, then model returns 32'h00500093, is_c=0, after 4 cycles.
//     -> iq_pc=0, iq_inst=32'h00500093, iq_is_c=0; next inst_addr=4.
//   2 At pc=4, model returns 32'h00004501, is_c=1.
//     -> entry {4, 32'h4501, 1}; next inst_addr=6.
//     -> then a 4-byte inst at 6 gives next inst_addr=10.
//   3 iq_ready=0, DEPTH=8 -> exactly 8 entries, then if_enable stays 0.
//     -> one dequeue restarts fetch; PCs in order, no duplicate or lost entry.
//   4 clear=1, clear_pc=32'h100, in the same cycle as if_ready with 2 entries queued.
//     -> iq_valid=0 next cycle; entry dropped; next request inst_addr=32'h100.
//   5 rdy_in=0 for 3 cycles while if_ready=1 -> no state change; one enqueue after rdy_in returns.
//   6 rst_n_in low between clock edges mid-WAIT.
//     -> if_enable=0, iq_valid=0 immediately; after release first fetch at RESET_PC.

Source files
------------

// File: rtl/inst_fetcher.sv
// inst_fetcher: holds the PC, issues one fetch at a time, and queues fetched instructions
// tagged with their PC for the decoder.
module inst_fetcher #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  output logic        if_enable,
  output logic [31:0] inst_addr,
  input  logic        if_ready,
  input  logic [31:0] inst,
  input  logic        is_c,
  output logic        iq_valid,
  input  logic        iq_ready,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic        iq_is_c
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc [DEPTH];
  logic [DEPTH-1:0] mem_c;
  logic clr, enq, deq;
  assign clr = rdy_in & clear;
  assign enq = rdy_in & ~clear & (state_q == WAIT) & if_ready;
  assign deq = rdy_in & ~clear & iq_valid & iq_ready;
  // Masked in the if_ready cycle so the controller never sees the stale address again
  assign if_enable = (state_q == WAIT) & ~if_ready;
  assign inst_addr = pc_q;
  assign iq_valid  = count_q != '0;
  assign iq_inst   = iq_valid ? mem_inst[head_q] : '0;
  assign iq_pc     = iq_valid ? mem_pc[head_q] : '0;
  assign iq_is_c   = iq_valid & mem_c[head_q];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (clr) begin
      state_d = IDLE;
      pc_d    = clear_pc;
    end else if (rdy_in) begin
      if (state_q == IDLE && count_q < (AW+1)'(DEPTH)) state_d = WAIT;
      else if (enq) begin
        state_d = IDLE;
        pc_d    = pc_q + (is_c ? 32'd2 : 32'd4);
      end
    end
    head_d  = clr ? '0 : head_q + AW'(deq);
    tail_d  = clr ? '0 : tail_q + AW'(enq);
    count_d = clr ? '0 : count_q + (AW+1)'(enq) - (AW+1)'(deq);
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (enq) begin
      mem_inst[tail_q] <= inst;
      mem_pc[tail_q]   <= pc_q;
      mem_c[tail_q]    <= is_c;
    end
  end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed stimulus against a transaction-level model of the fetch queue,
// compared every cycle, plus hand-computed literal expectations.
module tb_inst_fetcher;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] clear_pc = '0;
  logic        if_enable;
  logic [31:0] inst_addr;
  logic        if_ready = 1'b0;
  logic [31:0] inst = '0;
  logic        is_c = 1'b0;
  logic        iq_valid;
  logic        iq_ready = 1'b0;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_is_c;
  int checks = 0;
  int errors = 0;

  inst_fetcher #(.DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .clear(clear), .clear_pc(clear_pc),
    .if_enable(if_enable), .inst_addr(inst_addr), .if_ready(if_ready), .inst(inst),
    .is_c(is_c), .iq_valid(iq_valid), .iq_ready(iq_ready), .iq_inst(iq_inst),
    .iq_pc(iq_pc), .iq_is_c(iq_is_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        c;
  } entry_t;

  entry_t      q[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_busy = 1'b0;

  // Model: one outstanding request at a time, FIFO of fetched words, clear wipes everything
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0;
      m_busy = 1'b0;
      q.delete();
    end else if (rdy_in) begin
      if (clear) begin
        m_pc = clear_pc;
        m_busy = 1'b0;
        q.delete();
      end else begin
        bit start, pop, push;
        start = !m_busy && q.size() < 8;
        pop   = q.size() != 0 && iq_ready;
        push  = m_busy && if_ready;
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back('{pc: m_pc, ins: inst, c: is_c});
          m_pc = m_pc + (is_c ? 32'd2 : 32'd4);
          m_busy = 1'b0;
        end else if (start) m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_if_enable", if_enable, m_busy & ~if_ready);
    chk("m_inst_addr", inst_addr, m_pc);
    chk("m_iq_valid", iq_valid, q.size() != 0);
    chk("m_iq_pc", iq_pc, q.size() != 0 ? q[0].pc : 32'h0);
    chk("m_iq_inst", iq_inst, q.size() != 0 ? q[0].ins : 32'h0);
    chk("m_iq_is_c", iq_is_c, q.size() != 0 ? q[0].c : 1'b0);
  end

  task automatic serve(input logic [31:0] ins, input logic c, input int lat, input logic clr);
    int n = 0;
    while (!if_enable && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("serve_timeout", 32'(n), 32'd0);
    repeat (lat - 1) begin
      @(posedge clk); #1;
    end
    if_ready = 1'b1; inst = ins; is_c = c; clear = clr; clear_pc = 32'h100;
    @(posedge clk); #1;
    if_ready = 1'b0; clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_enable", if_enable, 0);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_iq_valid", iq_valid, 0);
    chk("rst_iq_inst", iq_inst, 32'h0);
    rst_n = 1'b1;
    serve(32'h00500093, 1'b0, 4, 1'b0);
    chk("t1_iq_pc", iq_pc, 32'h0);
    chk("t1_iq_inst", iq_inst, 32'h00500093);
    chk("t1_iq_is_c", iq_is_c, 0);
    chk("t1_inst_addr", inst_addr, 32'h4);
    serve(32'h00004501, 1'b1, 2, 1'b0);
    chk("t2_inst_addr", inst_addr, 32'h6);
    serve(32'h00a00113, 1'b0, 1, 1'b0);
    chk("t2_inst_addr2", inst_addr, 32'ha);
    iq_ready = 1'b1;
    @(posedge clk); #1;
    iq_ready = 1'b0;
    chk("t2_iq_pc", iq_pc, 32'h4);
    chk("t2_iq_inst", iq_inst, 32'h00004501);
    chk("t2_iq_is_c", iq_is_c, 1);
    for (int i = 0; i < 6; i++) serve(32'h10000000 + 32'(i), i[0], 1 + i % 3, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("t3_full_no_fetch", if_enable, 0);
    end
    iq_ready = 1'b1;
    @(posedge clk); #1;
    iq_ready = 1'b0;
    serve(32'h20000000, 1'b0, 2, 1'b0);
    chk("t3_full_again", iq_valid, 1);
    iq_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    iq_ready = 1'b0;
    chk("t3_drained", iq_valid, 0);
    serve(32'h30000000, 1'b0, 1, 1'b0);
    serve(32'h30000001, 1'b0, 2, 1'b0);
    serve(32'h30000002, 1'b0, 1, 1'b1);
    chk("t4_iq_valid", iq_valid, 0);
    chk("t4_no_issue", if_enable, 0);
    chk("t4_inst_addr", inst_addr, 32'h100);
    @(posedge clk); #1;
    chk("t4_issue", if_enable, 1);
    chk("t4_issue_addr", inst_addr, 32'h100);
    rdy_in = 1'b0; if_ready = 1'b1; inst = 32'h00108093; is_c = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t5_frozen_addr", inst_addr, 32'h100);
    chk("t5_frozen_iq", iq_valid, 0);
    rdy_in = 1'b1;
    @(posedge clk); #1;
    if_ready = 1'b0;
    chk("t5_iq_pc", iq_pc, 32'h100);
    chk("t5_iq_inst", iq_inst, 32'h00108093);
    chk("t5_inst_addr", inst_addr, 32'h104);
    @(posedge clk); #1;
    chk("t6_wait", if_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_if_enable", if_enable, 0);
    chk("t6_iq_valid", iq_valid, 0);
    chk("t6_inst_addr", inst_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    serve(32'h00000013, 1'b0, 3, 1'b0);
    chk("t6_iq_pc", iq_pc, 32'h0);
    chk("t6_iq_inst", iq_inst, 32'h00000013);
    chk("t6_inst_addr2", inst_addr, 32'h4);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
